fifo_rd_stream: RTL

- Read-side consumer for the team's async FIFO. It sits in the read clock domain and drives the FIFO read port: rd_en out, registered rdata back one cycle later, empty in.
- It re-presents the FIFO contents as a valid/ready stream toward downstream logic.
- It never issues a read while the FIFO is empty, sustains one word per cycle when downstream is always ready, and counts delivered words.

---
 rtl/fifo_rd_stream_pkg.sv | 6 +
 rtl/fifo_rd_stream_if.sv | 8 +
 rtl/fifo_rd_skid_buf.sv | 43 ++++
 rtl/fifo_rd_stream.sv | 54 +++++
 4 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// fifo_rd_stream_pkg: constants shared by the async FIFO and its read-side streamer
package fifo_rd_stream_pkg;
  localparam int BUF_DEPTH = 3;
  localparam int CNT_WIDTH_DEF = 16;
  typedef logic [1:0] occ_t;
endpackage

// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: valid/ready stream carried from the FIFO reader to downstream logic
interface fifo_rd_stream_if #(parameter int WIDTH = 8);
  logic valid;
  logic ready;
  logic [WIDTH-1:0] data;
  modport master (output valid, data, input ready);
  modport slave (input valid, data, output ready);
endinterface

// File: rtl/fifo_rd_skid_buf.sv
// fifo_rd_skid_buf: three-entry in-order register queue with simultaneous push and pop
module fifo_rd_skid_buf
  import fifo_rd_stream_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output occ_t             count_o,
  output logic [WIDTH-1:0] head_o
);
  logic [WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [WIDTH-1:0] mem_d [BUF_DEPTH];
  occ_t count_q, count_d, wr_idx;
  assign wr_idx = count_q - occ_t'(pop_i);
  // shift toward the head on pop, then place the pushed word behind the survivors
  always_comb begin
    mem_d[0] = pop_i ? mem_q[1] : mem_q[0];
    mem_d[1] = pop_i ? mem_q[2] : mem_q[1];
    mem_d[2] = pop_i ? '0 : mem_q[2];
    if (push_i && wr_idx < occ_t'(BUF_DEPTH)) mem_d[wr_idx] = din_i;
    count_d = count_q + occ_t'(push_i) - occ_t'(pop_i);
  end
  // queue storage and occupancy
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mem_q   <= '{default: '0};
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
    end
  end
  // the upstream credit scheme must never let a push land on a full queue
  always_ff @(posedge clk_i) begin
    if (rst_n_i) assert (!(push_i && !pop_i && count_q == occ_t'(BUF_DEPTH)));
  end
  assign count_o = count_q;
  assign head_o  = mem_q[0];
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains the async FIFO read port into a valid/ready stream with credit-based reads
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 fifo_empty_i,
  output logic                 fifo_rd_en_o,
  input  logic [WIDTH-1:0]     fifo_rdata_i,
  input  logic                 fifo_rd_error_i,
  fifo_rd_stream_if.master     m,
  output logic [CNT_WIDTH-1:0] rd_count_o,
  output logic                 err_o
);
  occ_t count;
  logic inflight_q, inflight_d, err_q, err_d, push, pop;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  assign fifo_rd_en_o = rst_n_i && !fifo_empty_i && ({1'b0, count} + {2'b0, inflight_q} < 3'(BUF_DEPTH));
  assign push    = inflight_q && !fifo_rd_error_i;
  assign pop     = m.valid && m.ready;
  assign m.valid = count != '0;
  fifo_rd_skid_buf #(.WIDTH(WIDTH)) u_buf (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (fifo_rdata_i),
    .count_o (count),
    .head_o  (m.data)
  );
  // next state: track the outstanding read, latch errors, count accepted words
  always_comb begin
    inflight_d = fifo_rd_en_o;
    err_d      = err_q | fifo_rd_error_i;
    cnt_d      = cnt_q + CNT_WIDTH'(pop);
  end
  // state registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      inflight_q <= inflight_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end
  assign rd_count_o = cnt_q;
  assign err_o      = err_q;
endmodule
